// File: rtl/pn_pkg.sv
// Shared definitions for the Polish-notation evaluator: mode and opcode
// encodings plus the control FSM state type.
package pn_pkg;

    localparam logic PN_POSTFIX = 1'b0;
    localparam logic PN_PREFIX  = 1'b1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ABS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EVAL = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/pn_alu.sv
// Combinational evaluator ALU. All results wrap modulo 2^DATA_W.
// Ports: a, b - operands; op - opcode; result - a op b.
module pn_alu
    import pn_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] diff;

    assign diff = a - b;

    // |a-b| negates a negative difference; the most-negative value maps to itself
    always_comb begin
        result = a + b;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = diff;
            OP_MUL:  result = a * b;
            OP_ABS:  result = diff[DATA_W-1] ? -diff : diff;
            default: result = a + b;
        endcase
    end

endmodule

// File: rtl/pn_eval_core.sv
// Streaming prefix/postfix expression evaluator.
// Ports: clk, rst (sync, active high); in_valid/mode/operator/in - token
// stream; busy - burst in progress; out_valid/out/err - result stream,
// err marks a malformed burst (single cycle, out = 0).
module pn_eval_core
    import pn_pkg::*;
#(
    parameter int unsigned OPND_W    = 3,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TOK_DEPTH = 16,
    parameter int unsigned STK_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     mode,
    input  logic                     operator,
    input  logic [OPND_W-1:0]        in,
    output logic                     busy,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out,
    output logic                     err
);

    localparam int unsigned TOK_W  = OPND_W + 1;
    localparam int unsigned TCNT_W = $clog2(TOK_DEPTH + 1);
    localparam int unsigned TIDX_W = (TOK_DEPTH > 1) ? $clog2(TOK_DEPTH) : 1;
    localparam int unsigned SCNT_W = $clog2(STK_DEPTH + 1);
    localparam int unsigned SIDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

    state_t state, state_d;

    logic [TOK_W-1:0]  tok_mem [TOK_DEPTH];
    logic [DATA_W-1:0] stk     [STK_DEPTH];

    logic [TCNT_W-1:0] tok_cnt, tok_cnt_d;
    logic [TCNT_W-1:0] ev_cnt, ev_cnt_d;
    logic [SCNT_W-1:0] sp, sp_d;
    logic [SCNT_W-1:0] out_cnt, out_cnt_d;
    logic              mode_q, mode_d;
    logic              tok_ovf, tok_ovf_d;
    logic              eval_err, eval_err_d;
    logic              busy_d, out_valid_d, err_d;
    logic [DATA_W-1:0] out_d;

    logic              tok_we;
    logic [TIDX_W-1:0] tok_wa;
    logic              stk_we;
    logic [SIDX_W-1:0] stk_wa;
    logic [DATA_W-1:0] stk_wd;

    logic [TCNT_W-1:0] tok_pos;
    logic [TOK_W-1:0]  cur_tok;
    logic [DATA_W-1:0] stk_top, stk_sec, alu_a, alu_b, alu_res;
    logic [SCNT_W-1:0] out_pos;

    // Prefix scans the stored tokens from the end back to the start
    assign tok_pos = (mode_q == PN_PREFIX) ? (tok_cnt - ev_cnt - TCNT_W'(1)) : ev_cnt;
    assign cur_tok = tok_mem[TIDX_W'(tok_pos)];
    assign stk_top = stk[SIDX_W'(sp - SCNT_W'(1))];
    assign stk_sec = stk[SIDX_W'(sp - SCNT_W'(2))];
    assign alu_a   = (mode_q == PN_PREFIX) ? stk_top : stk_sec;
    assign alu_b   = (mode_q == PN_PREFIX) ? stk_sec : stk_top;
    // Leftmost expression sits at the bottom for postfix, at the top for prefix
    assign out_pos = (mode_q == PN_PREFIX) ? (sp - out_cnt - SCNT_W'(1)) : out_cnt;

    pn_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (cur_tok[1:0]),
        .result (alu_res)
    );

    // Next-state, datapath control and output next values
    always_comb begin
        state_d     = state;
        busy_d      = busy;
        out_valid_d = 1'b0;
        out_d       = '0;
        err_d       = 1'b0;
        tok_cnt_d   = tok_cnt;
        ev_cnt_d    = ev_cnt;
        sp_d        = sp;
        out_cnt_d   = out_cnt;
        mode_d      = mode_q;
        tok_ovf_d   = tok_ovf;
        eval_err_d  = eval_err;
        tok_we      = 1'b0;
        tok_wa      = '0;
        stk_we      = 1'b0;
        stk_wa      = '0;
        stk_wd      = '0;

        case (state)
            IDLE: begin
                busy_d = 1'b0;
                // busy still high here means the previous burst just finished
                if (in_valid && !busy) begin
                    tok_we    = 1'b1;
                    tok_wa    = '0;
                    tok_cnt_d = TCNT_W'(1);
                    mode_d    = mode;
                    tok_ovf_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = READ;
                end
            end
            READ: begin
                if (in_valid) begin
                    if (tok_cnt == TCNT_W'(TOK_DEPTH)) begin
                        tok_ovf_d = 1'b1;
                    end else begin
                        tok_we    = 1'b1;
                        tok_wa    = TIDX_W'(tok_cnt);
                        tok_cnt_d = tok_cnt + TCNT_W'(1);
                    end
                end else begin
                    ev_cnt_d   = '0;
                    sp_d       = '0;
                    out_cnt_d  = '0;
                    eval_err_d = tok_ovf;
                    state_d    = EVAL;
                end
            end
            EVAL: begin
                ev_cnt_d = ev_cnt + TCNT_W'(1);
                if (ev_cnt == tok_cnt - TCNT_W'(1)) begin
                    state_d = OUT;
                end
                // After the first error the remaining tokens are consumed without effect
                if (!eval_err) begin
                    if (cur_tok[TOK_W-1]) begin
                        if (sp < SCNT_W'(2)) begin
                            eval_err_d = 1'b1;
                        end else begin
                            stk_we = 1'b1;
                            stk_wa = SIDX_W'(sp - SCNT_W'(2));
                            stk_wd = alu_res;
                            sp_d   = sp - SCNT_W'(1);
                        end
                    end else begin
                        if (sp == SCNT_W'(STK_DEPTH)) begin
                            eval_err_d = 1'b1;
                        end else begin
                            stk_we = 1'b1;
                            stk_wa = SIDX_W'(sp);
                            stk_wd = DATA_W'(cur_tok[OPND_W-1:0]);
                            sp_d   = sp + SCNT_W'(1);
                        end
                    end
                end
            end
            OUT: begin
                out_valid_d = 1'b1;
                if (eval_err || sp == '0) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    out_d     = stk[SIDX_W'(out_pos)];
                    out_cnt_d = out_cnt + SCNT_W'(1);
                    if (out_cnt == sp - SCNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, outputs and storage arrays
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            err       <= 1'b0;
            tok_cnt   <= '0;
            ev_cnt    <= '0;
            sp        <= '0;
            out_cnt   <= '0;
            mode_q    <= PN_POSTFIX;
            tok_ovf   <= 1'b0;
            eval_err  <= 1'b0;
            for (int i = 0; i < int'(TOK_DEPTH); i++) tok_mem[i] <= '0;
            for (int i = 0; i < int'(STK_DEPTH); i++) stk[i] <= '0;
        end else begin
            state     <= state_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
            out       <= out_d;
            err       <= err_d;
            tok_cnt   <= tok_cnt_d;
            ev_cnt    <= ev_cnt_d;
            sp        <= sp_d;
            out_cnt   <= out_cnt_d;
            mode_q    <= mode_d;
            tok_ovf   <= tok_ovf_d;
            eval_err  <= eval_err_d;
            if (tok_we) tok_mem[tok_wa] <= {operator, in};
            if (stk_we) stk[stk_wa] <= stk_wd;
        end
    end

endmodule

// File: tb/tb_pn_eval_core.sv
// Directed bench for pn_eval_core: a default 32-bit instance and a 4-bit
// instance share one token stream.
module tb_pn_eval_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        mode;
    logic        operator;
    logic [2:0]  in;
    logic        busy, out_valid, err;
    logic [31:0] out;
    logic        busy4, out_valid4, err4;
    logic [3:0]  out4;

    int ncmp  = 0;
    int nfail = 0;
    int lat;
    logic [31:0] res_q[$];
    logic [3:0]  res4_q[$];
    logic        err_q[$];

    pn_eval_core u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
        .operator(operator), .in(in), .busy(busy), .out_valid(out_valid),
        .out(out), .err(err)
    );

    pn_eval_core #(.DATA_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
        .operator(operator), .in(in), .busy(busy4), .out_valid(out_valid4),
        .out(out4), .err(err4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tokens: digits 0-7 are operands, + - * | are operators (| = abs diff)
    task automatic send(input string s, input logic md);
        for (int i = 0; i < s.len(); i++) begin
            byte c;
            c = s[i];
            @(negedge clk);
            in_valid = 1'b1;
            mode     = md;
            operator = 1'b1;
            case (c)
                "+":     in = 3'd0;
                "-":     in = 3'd1;
                "*":     in = 3'd2;
                "|":     in = 3'd3;
                default: begin operator = 1'b0; in = 3'(c - "0"); end
            endcase
        end
        @(negedge clk);
        in_valid = 1'b0;
        operator = 1'b0;
        in       = '0;
    endtask

    // Called at the negedge where in_valid was dropped
    task automatic collect(input string tag);
        int cyc;
        cyc = 0;
        res_q.delete();
        res4_q.delete();
        err_q.delete();
        while (!out_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_timeout"}, 32'(out_valid), 32'd1);
        lat = cyc - 1;
        while (out_valid && res_q.size() < 20) begin
            res_q.push_back(out);
            res4_q.push_back(out4);
            err_q.push_back(err);
            @(negedge clk);
        end
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        check({tag, "_out_idle"}, out, 32'd0);
    endtask

    initial begin
        int ov_seen;
        rst      = 1'b1;
        in_valid = 1'b0;
        mode     = 1'b0;
        operator = 1'b0;
        in       = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // postfix 3 4 -  -> -1, latency L+1 = 4
        send("34-", 1'b0);
        collect("pf_sub");
        check("pf_sub_n", 32'(res_q.size()), 32'd1);
        check("pf_sub_lat", 32'(lat), 32'd4);
        check("pf_sub_val", res_q[0], 32'hFFFF_FFFF);
        check("pf_sub_err", 32'(err_q[0]), 32'd0);

        // prefix - 3 4 -> -1
        send("-34", 1'b1);
        collect("px_sub");
        check("px_sub_n", 32'(res_q.size()), 32'd1);
        check("px_sub_val", res_q[0], 32'hFFFF_FFFF);

        // prefix * + 1 2 7 -> 21, latency 6
        send("*+127", 1'b1);
        collect("px_mul");
        check("px_mul_n", 32'(res_q.size()), 32'd1);
        check("px_mul_lat", 32'(lat), 32'd6);
        check("px_mul_val", res_q[0], 32'd21);
        check("px_mul_err", 32'(err_q[0]), 32'd0);

        // postfix burst of two expressions: 3 then |7-5| = 2
        send("12+75|", 1'b0);
        collect("pf_two");
        check("pf_two_n", 32'(res_q.size()), 32'd2);
        check("pf_two_v0", res_q[0], 32'd3);
        check("pf_two_v1", res_q[1], 32'd2);
        check("pf_two_e0", 32'(err_q[0]), 32'd0);
        check("pf_two_e1", 32'(err_q[1]), 32'd0);

        // prefix burst of two expressions: -1 first, then 3
        send("-34+12", 1'b1);
        collect("px_two");
        check("px_two_n", 32'(res_q.size()), 32'd2);
        check("px_two_v0", res_q[0], 32'hFFFF_FFFF);
        check("px_two_v1", res_q[1], 32'd3);

        // stack underflow
        send("5+", 1'b0);
        collect("underflow");
        check("underflow_n", 32'(res_q.size()), 32'd1);
        check("underflow_err", 32'(err_q[0]), 32'd1);
        check("underflow_val", res_q[0], 32'd0);

        // nine operands with an 8-entry stack
        send("123456712", 1'b0);
        collect("stk_ovf");
        check("stk_ovf_n", 32'(res_q.size()), 32'd1);
        check("stk_ovf_err", 32'(err_q[0]), 32'd1);
        check("stk_ovf_val", res_q[0], 32'd0);

        // 7*7 = 49; wraps to 1 in the 4-bit instance without error
        send("77*", 1'b0);
        collect("mul_wrap");
        check("mul_wrap_n", 32'(res_q.size()), 32'd1);
        check("mul_wrap_v32", res_q[0], 32'd49);
        check("mul_wrap_v4", 32'(res4_q[0]), 32'd1);
        check("mul_wrap_err", 32'(err_q[0]), 32'd0);

        // |(0-7-1) - 0|: 4-bit most-negative -8 wraps to itself (4'h8)
        send("07-1-0|", 1'b0);
        collect("abs_min");
        check("abs_min_v32", res_q[0], 32'd8);
        check("abs_min_v4", 32'(res4_q[0]), 32'h8);
        check("abs_min_err", 32'(err_q[0]), 32'd0);

        // 17 tokens into a 16-token buffer, otherwise well-formed
        send("11+1+1+1+1+1+1+1+", 1'b0);
        collect("tok_ovf");
        check("tok_ovf_n", 32'(res_q.size()), 32'd1);
        check("tok_ovf_err", 32'(err_q[0]), 32'd1);
        check("tok_ovf_val", res_q[0], 32'd0);

        // reset mid-EVAL, with a token offered during the reset cycle
        send("23+", 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in       = 3'd6;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        in       = '0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        ov_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid || busy) ov_seen++;
        end
        check("mid_rst_quiet", 32'(ov_seen), 32'd0);

        send("23+", 1'b0);
        collect("after_rst");
        check("after_rst_n", 32'(res_q.size()), 32'd1);
        check("after_rst_val", res_q[0], 32'd5);
        check("after_rst_err", 32'(err_q[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/pn_eval_core.md
Name: pn_eval_core

Overview:
- Parametrised Polish-notation evaluator, successor to the fixed 4-bit final-project evaluator.
- Accepts a streamed token sequence and evaluates it in prefix or postfix order using an internal register-array stack.
- A burst may hold several independent expressions; every result left on the stack is emitted, in expression order, one per cycle.
- Adds configurable operand/result width, token depth and stack depth, plus an error flag for malformed input.

Parameters:
- OPND_W, 3: operand / opcode field width of `in`.
- DATA_W, 32: signed result and stack-entry width.
- TOK_DEPTH, 16: maximum tokens per burst.
- STK_DEPTH, 8: evaluation stack entries.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  token valid; a contiguous high run forms one burst.
- mode  in  1  0 = postfix, 1 = prefix; sampled on the first in_valid cycle of a burst.
- operator  in  1  1 = token is an operator, 0 = operand.
- in  in  OPND_W  operand value (unsigned), or opcode in bits [1:0].
- busy  out  1  high from the first accepted token until the last output cycle.
- out_valid  out  1  result strobe.
- out  out  DATA_W  signed result; 0 when out_valid is low.
- err  out  1  qualifies out_valid; marks a malformed burst.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; busy, out_valid, err = 0; out = 0; stack, token and result counters cleared. Applies in any state, aborting a burst in progress; no further out_valid for the aborted burst.
- FSM IDLE -> READ -> EVAL -> OUT -> IDLE.
  - IDLE: first in_valid stores token 0, latches mode, goes to READ.
  - READ: stores one token per in_valid cycle. The first in_valid-low cycle goes to EVAL.
  - EVAL: one token per cycle. Postfix scans index 0 upward; prefix scans index L-1 downward.
  - OUT: emits the k stack entries, one per cycle, then returns to IDLE.
- in_valid while busy and not in READ is ignored; a gap ends the burst.
- Token storage: {operator, in}, TOK_DEPTH entries. The (TOK_DEPTH+1)th token sets a sticky token-overflow flag; further tokens are discarded.
- Operand token: zero-extend to DATA_W and push.
- Operator token: pop two entries and push one result, all in the same cycle.
  - Postfix: a = second-from-top, b = top.
  - Prefix: a = top, b = second-from-top.
- Opcodes in[1:0]: 00 a+b, 01 a-b, 10 a*b (low DATA_W bits), 11 |a-b|. All arithmetic is two's complement and wraps modulo 2^DATA_W; |a-b| of the most-negative value wraps to itself.
- Errors are sticky per burst; evaluation still consumes remaining tokens with no stack effect after the first error.
  - Underflow: operator with fewer than 2 entries on the stack.
  - Overflow: push with STK_DEPTH entries on the stack.
  - Token overflow (above).
  - Burst ending with an empty stack.
- OUT on error: exactly one cycle with out_valid=1, err=1, out=0.
- OUT with no error: k cycles, out_valid=1, err=0.
  - Postfix: stack index 0 upward.
  - Prefix: top downward.
  - Either way the leftmost expression in the input is emitted first.
- Latency: with L tokens stored, EVAL takes exactly L cycles. The first out_valid is high L+1 cycles after the first cycle in which in_valid is sampled low, including a one-cycle EVAL->OUT handoff. out_valid stays high for k consecutive cycles (1 on error).
- busy drops in the cycle after the last out_valid. A new burst can start in the cycle following busy low.
- A token arriving in the same cycle rst is high is discarded.

Decomposition:
- Shared package pn_pkg:
  - mode constants: PN_POSTFIX, PN_PREFIX
  - opcode constants: OP_ADD, OP_SUB, OP_MUL, OP_ABS
  - FSM state encodings: IDLE, READ, EVAL, OUT
- One combinational sub-module pn_alu (DATA_W parameter): inputs a, b, op; output result.
- The stack and token buffer stay in pn_eval_core as register arrays.

Test Plan:
- Postfix 3 4 - (operator on '-'), DATA_W=32 -> single out_valid, out = -1 (0xFFFFFFFF), err=0; first out_valid 4 cycles after in_valid falls.
- Prefix - 3 4 -> out = -1. Prefix * + 1 2 7 -> out = 21.
- Postfix burst 1 2 + 7 5 | (| = ABS) -> two out_valid cycles, 3 then 2, err=0.
- Postfix 5 + (underflow) -> one cycle out_valid=1, err=1, out=0. Nine operands with STK_DEPTH=8 -> err=1.
- DATA_W=4, postfix 7 7 * -> out = 1 (49 mod 16) with wrap and no err. 17 tokens with TOK_DEPTH=16 -> err=1.
- rst asserted mid-EVAL -> next cycle busy=0, no out_valid. A following postfix 2 3 + burst returns 5.
